// File: rtl/stack_alu.sv
// stack_alu: sequential ALU for the stack CPU's calc-store path.
// It takes the top two stack words (tos, nos) and produces a registered result with persistent carry/zero flags.
// MUL is a multi-cycle shift-add operation; every other opcode completes in one cycle.
module stack_alu #(
  parameter int WIDTH      = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] tos,
  input  logic [WIDTH-1:0] nos,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_ADDC = 4'h1, OP_SUB = 4'h2, OP_SUBC = 4'h3,
    OP_AND  = 4'h4, OP_OR   = 4'h5, OP_XOR = 4'h6, OP_NOT  = 4'h7,
    OP_SHL  = 4'h8, OP_SHR  = 4'h9, OP_ROL = 4'hA, OP_ROR  = 4'hB,
    OP_INC  = 4'hC, OP_DEC  = 4'hD, OP_CMP = 4'hE, OP_MUL  = 4'hF
  } op_t;

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c;
  logic               alu_z;
  logic               alu_upd;

  // Single-cycle datapath: result and flags for every opcode except MUL.
  always_comb begin
    sum     = '0;
    alu_r   = '0;
    alu_c   = carry;
    alu_z   = 1'b0;
    alu_upd = 1'b1;
    case (opcode)
      OP_ADD:  begin sum = {1'b0, nos} + {1'b0, tos};                        alu_r = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
      OP_ADDC: begin sum = {1'b0, nos} + {1'b0, tos} + (WIDTH+1)'(carry);    alu_r = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
      OP_SUB:  begin sum = {1'b0, nos} - {1'b0, tos};                        alu_r = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
      OP_SUBC: begin sum = {1'b0, nos} - {1'b0, tos} - (WIDTH+1)'(carry);    alu_r = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
      OP_AND:  alu_r = nos & tos;
      OP_OR:   alu_r = nos | tos;
      OP_XOR:  alu_r = nos ^ tos;
      OP_NOT:  alu_r = ~tos;
      OP_SHL:  begin alu_r = {tos[WIDTH-2:0], 1'b0};       alu_c = tos[WIDTH-1]; end
      OP_SHR:  begin alu_r = {1'b0, tos[WIDTH-1:1]};       alu_c = tos[0];       end
      OP_ROL:  begin alu_r = {tos[WIDTH-2:0], tos[WIDTH-1]}; alu_c = tos[WIDTH-1]; end
      OP_ROR:  begin alu_r = {tos[0], tos[WIDTH-1:1]};     alu_c = tos[0];       end
      OP_INC:  begin sum = {1'b0, tos} + (WIDTH+1)'(1); alu_r = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
      OP_DEC:  begin sum = {1'b0, tos} - (WIDTH+1)'(1); alu_r = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
      OP_CMP:  begin alu_upd = 1'b0; alu_c = (nos < tos); alu_z = (nos == tos); end
      default: alu_upd = 1'b0;
    endcase
    if (alu_upd) alu_z = (alu_r == '0);
  end

  // Shift-add step: the multiplicand and multiplier are pre-shifted, so only bit 0 of the multiplier is tested each cycle.
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  // Control FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      result    <= '0;
      result_hi <= '0;
      carry     <= 1'b0;
      zero      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (opcode == OP_MUL) begin
              mcand  <= {{WIDTH{1'b0}}, nos};
              mplier <= tos;
              acc    <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= S_MUL;
            end else begin
              if (alu_upd) begin
                result    <= alu_r;
                result_hi <= '0;
              end
              carry <= alu_c;
              zero  <= alu_z;
              done  <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(MUL_CYCLES - 1)) begin
            result    <= acc_next[WIDTH-1:0];
            result_hi <= acc_next[2*WIDTH-1:WIDTH];
            carry     <= |acc_next[2*WIDTH-1:WIDTH];
            zero      <= (acc_next == '0);
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_alu.sv
// Testbench for stack_alu: directed vectors plus a per-cycle comparison against an arithmetic reference model.
module tb_stack_alu;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] opcode;
  logic [3:0] tos;
  logic [3:0] nos;
  logic [3:0] result;
  logic [3:0] result_hi;
  logic       carry;
  logic       zero;
  logic       busy;
  logic       done;

  int tests;
  int fails;
  bit chk_en;

  stack_alu #(.WIDTH(4), .MUL_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .tos(tos), .nos(nos),
    .result(result), .result_hi(result_hi), .carry(carry), .zero(zero),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic on the operand values, and a countdown for MUL latency.
  int m_result, m_hi, m_carry, m_zero, m_busy, m_done, m_left, m_prod;

  always @(posedge clk) begin
    int a, b, s, r, c;
    bit upd;
    a = int'(nos);
    b = int'(tos);
    m_done = 0;
    if (rst) begin
      m_result = 0; m_hi = 0; m_carry = 0; m_zero = 1; m_busy = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_result = m_prod % 16;
        m_hi     = m_prod / 16;
        m_carry  = (m_prod >= 16);
        m_zero   = (m_prod == 0);
        m_busy   = 0;
        m_done   = 1;
      end
    end else if (start) begin
      upd = 1; r = 0; c = m_carry;
      case (opcode)
        4'h0: begin s = a + b;           r = s % 16; c = (s > 15); end
        4'h1: begin s = a + b + m_carry; r = s % 16; c = (s > 15); end
        4'h2: begin r = (a - b + 16) % 16;           c = (a < b); end
        4'h3: begin r = (a - b - m_carry + 32) % 16; c = (a < b + m_carry); end
        4'h4: r = a & b;
        4'h5: r = a | b;
        4'h6: r = a ^ b;
        4'h7: r = 15 - b;
        4'h8: begin r = (b * 2) % 16;           c = (b >= 8); end
        4'h9: begin r = b / 2;                  c = b % 2; end
        4'hA: begin r = (b * 2) % 16 + b / 8;   c = (b >= 8); end
        4'hB: begin r = b / 2 + (b % 2) * 8;    c = b % 2; end
        4'hC: begin r = (b + 1) % 16;           c = (b == 15); end
        4'hD: begin r = (b + 15) % 16;          c = (b == 0); end
        4'hE: begin upd = 0; m_carry = (a < b); m_zero = (a == b); end
        default: begin upd = 0; m_prod = a * b; m_left = 4; m_busy = 1; end
      endcase
      if (upd) begin
        m_result = r; m_hi = 0; m_carry = c; m_zero = (r == 0); m_done = 1;
      end else if (opcode == 4'hE) begin
        m_done = 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_result",    int'(result),    m_result);
      check("m_result_hi", int'(result_hi), m_hi);
      check("m_carry",     int'(carry),     m_carry);
      check("m_zero",      int'(zero),      m_zero);
      check("m_busy",      int'(busy),      m_busy);
      check("m_done",      int'(done),      m_done);
    end
  end

  task automatic do_op(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    opcode = op; nos = a; tos = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", int'(done), 1);
  endtask

  typedef struct packed {
    logic [3:0] op; logic [3:0] a; logic [3:0] b; logic [3:0] r; logic c; logic z;
  } vec_t;

  typedef struct packed {
    logic [3:0] a; logic [3:0] b; logic [3:0] r; logic [3:0] hi; logic c; logic z;
  } mvec_t;

  vec_t  vt [20];
  mvec_t mt [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // op, nos, tos -> result, carry, zero (carry chains from row to row)
    vt = '{
      '{4'h0, 4'h9, 4'h8, 4'h1, 1'b1, 1'b0},
      '{4'h1, 4'h2, 4'h3, 4'h6, 1'b0, 1'b0},
      '{4'h2, 4'h3, 4'h5, 4'hE, 1'b1, 1'b0},
      '{4'hE, 4'h7, 4'h7, 4'hE, 1'b0, 1'b1},
      '{4'hA, 4'h0, 4'h9, 4'h3, 1'b1, 1'b0},
      '{4'h9, 4'h0, 4'h1, 4'h0, 1'b1, 1'b1},
      '{4'h3, 4'h5, 4'h3, 4'h1, 1'b0, 1'b0},
      '{4'h3, 4'h3, 4'h3, 4'h0, 1'b0, 1'b1},
      '{4'h1, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1},
      '{4'h3, 4'h4, 4'h4, 4'hF, 1'b1, 1'b0},
      '{4'h4, 4'hC, 4'hA, 4'h8, 1'b1, 1'b0},
      '{4'h5, 4'h5, 4'hA, 4'hF, 1'b1, 1'b0},
      '{4'h6, 4'hF, 4'hF, 4'h0, 1'b1, 1'b1},
      '{4'h7, 4'h0, 4'hA, 4'h5, 1'b1, 1'b0},
      '{4'h8, 4'h0, 4'h6, 4'hC, 1'b0, 1'b0},
      '{4'hB, 4'h0, 4'h3, 4'h9, 1'b1, 1'b0},
      '{4'hC, 4'h0, 4'h7, 4'h8, 1'b0, 1'b0},
      '{4'hD, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0},
      '{4'hE, 4'h2, 4'h9, 4'hF, 1'b1, 1'b0},
      '{4'h0, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1}
    };
    // nos, tos -> result, result_hi, carry, zero
    mt = '{
      '{4'hD, 4'hB, 4'hF, 4'h8, 1'b1, 1'b0},
      '{4'hF, 4'hF, 4'h1, 4'hE, 1'b1, 1'b0},
      '{4'h0, 4'h7, 4'h0, 4'h0, 1'b0, 1'b1},
      '{4'h3, 4'h5, 4'hF, 4'h0, 1'b0, 1'b0}
    };

    tests = 0; fails = 0; chk_en = 1'b0;
    rst = 1'b1; start = 1'b0; opcode = '0; tos = '0; nos = '0;

    // Reset state
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_result", int'(result), 0);
    check("rst_hi",     int'(result_hi), 0);
    check("rst_carry",  int'(carry), 0);
    check("rst_zero",   int'(zero), 1);
    check("rst_busy",   int'(busy), 0);
    check("rst_done",   int'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single-cycle opcodes
    for (int i = 0; i < 20; i++) begin
      do_op(vt[i].op, vt[i].a, vt[i].b);
      check($sformatf("vec%0d_done", i),   int'(done), 1);
      check($sformatf("vec%0d_result", i), int'(result), int'(vt[i].r));
      check($sformatf("vec%0d_carry", i),  int'(carry), int'(vt[i].c));
      check($sformatf("vec%0d_zero", i),   int'(zero), int'(vt[i].z));
      check($sformatf("vec%0d_hi", i),     int'(result_hi), 0);
    end

    // Back-to-back starts on consecutive cycles
    @(negedge clk);
    opcode = 4'h0; nos = 4'h1; tos = 4'h1; start = 1'b1;
    @(negedge clk);
    check("b2b_done1",   int'(done), 1);
    check("b2b_result1", int'(result), 2);
    nos = 4'h2; tos = 4'h2;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done2",   int'(done), 1);
    check("b2b_result2", int'(result), 4);

    // MUL with a start issued while busy, which must be dropped
    do_op(4'hF, 4'hD, 4'hB);
    check("mul_busy1", int'(busy), 1);
    check("mul_done_early", int'(done), 0);
    @(negedge clk);
    opcode = 4'h0; nos = 4'h1; tos = 4'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mul_busy3", int'(busy), 1);
    wait_done();
    check("mul0_result", int'(result), 15);
    check("mul0_hi",     int'(result_hi), 8);
    check("mul0_carry",  int'(carry), 1);
    check("mul0_busy",   int'(busy), 0);
    repeat (2) begin
      @(negedge clk);
      check("mul0_no_extra_done", int'(done), 0);
      check("mul0_hold",          int'(result), 15);
    end

    // MUL table
    for (int i = 0; i < 4; i++) begin
      do_op(4'hF, mt[i].a, mt[i].b);
      wait_done();
      check($sformatf("mul%0d_result", i), int'(result), int'(mt[i].r));
      check($sformatf("mul%0d_hi", i),     int'(result_hi), int'(mt[i].hi));
      check($sformatf("mul%0d_carry", i),  int'(carry), int'(mt[i].c));
      check($sformatf("mul%0d_zero", i),   int'(zero), int'(mt[i].z));
    end

    // Start accepted in the done cycle of a MUL
    opcode = 4'hC; nos = 4'h0; tos = 4'h2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("after_mul_done", int'(done), 1);
    check("after_mul_result", int'(result), 3);
    check("after_mul_hi", int'(result_hi), 0);

    // Reset in the middle of a MUL
    do_op(4'hF, 4'hF, 4'hF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",   int'(busy), 0);
    check("abort_result", int'(result), 0);
    check("abort_hi",     int'(result_hi), 0);
    check("abort_zero",   int'(zero), 1);
    check("abort_done",   int'(done), 0);
    repeat (5) begin
      @(negedge clk);
      check("abort_no_done", int'(done), 0);
    end
    do_op(4'hC, 4'h0, 4'hF);
    check("inc_wrap_result", int'(result), 0);
    check("inc_wrap_carry",  int'(carry), 1);
    check("inc_wrap_zero",   int'(zero), 1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
